// File: rtl/loop_nest_ctrl.sv
// Nested-loop index generator: latches per-level bounds on start and streams one
// index tuple per accepted beat, odometer style, with first/last flags per level.
module loop_nest_ctrl #(
  parameter int NDepth = 3,
  parameter int IdxDW  = 11
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [NDepth*IdxDW-1:0] i_bound,
  input  logic                    i_abort,
  output logic                    o_busy,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [NDepth*IdxDW-1:0] o_idx,
  output logic [NDepth-1:0]       o_first,
  output logic [NDepth-1:0]       o_last,
  output logic                    o_done
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t                         state_reg;
  logic [NDepth-1:0][IdxDW-1:0]   idx_reg;
  logic [NDepth-1:0][IdxDW-1:0]   bound_reg;
  logic [NDepth-1:0][IdxDW-1:0]   idx_next;
  logic [NDepth-1:0][IdxDW-1:0]   bound_in;
  logic [NDepth-1:0]              carry;
  logic                           busy_reg;
  logic                           valid_reg;
  logic                           done_reg;
  logic                           beat;
  logic                           final_beat;

  genvar gi;
  generate
    for (gi = 0; gi < NDepth; gi++) begin : g_level
      // A zero bound is treated as a single iteration.
      assign bound_in[gi] = (i_bound[gi*IdxDW +: IdxDW] == '0) ? IdxDW'(1)
                                                              : i_bound[gi*IdxDW +: IdxDW];
      assign o_first[gi]  = (idx_reg[gi] == '0);
      assign o_last[gi]   = (idx_reg[gi] == bound_reg[gi] - IdxDW'(1));

      if (gi == 0) begin : g_carry0
        assign carry[gi] = 1'b1;
      end else begin : g_carryn
        assign carry[gi] = &o_last[gi-1:0];
      end

      assign idx_next[gi] = carry[gi] ? (o_last[gi] ? '0 : idx_reg[gi] + IdxDW'(1))
                                      : idx_reg[gi];
    end
  endgenerate

  assign beat       = valid_reg & i_ready;
  assign final_beat = &o_last;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      valid_reg <= 1'b0;
      done_reg  <= 1'b0;
      idx_reg   <= '0;
      for (int k = 0; k < NDepth; k++) bound_reg[k] <= IdxDW'(1);
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
            valid_reg <= 1'b1;
            bound_reg <= bound_in;
            idx_reg   <= '0;
          end
        end
        ST_RUN: begin
          // Abort wins over a same-cycle beat; indices stay where they are.
          if (i_abort) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
          end else if (beat) begin
            if (final_beat) begin
              state_reg <= ST_IDLE;
              busy_reg  <= 1'b0;
              valid_reg <= 1'b0;
              done_reg  <= 1'b1;
            end else begin
              idx_reg <= idx_next;
            end
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy  = busy_reg;
  assign o_valid = valid_reg;
  assign o_done  = done_reg;
  assign o_idx   = idx_reg;

endmodule

// File: tb/tb_loop_nest_ctrl.sv
// Self-checking bench for loop_nest_ctrl: expected tuples come from the beat
// number by mixed-radix division, independent of the odometer in the design.
module tb_loop_nest_ctrl;
  localparam int ND = 3;
  localparam int W  = 11;

  logic            i_clk = 1'b0;
  logic            i_rstn = 1'b0;
  logic            i_start = 1'b0;
  logic [ND*W-1:0] i_bound = '0;
  logic            i_abort = 1'b0;
  logic            o_busy;
  logic            o_valid;
  logic            i_ready = 1'b0;
  logic [ND*W-1:0] o_idx;
  logic [ND-1:0]   o_first;
  logic [ND-1:0]   o_last;
  logic            o_done;

  int checks = 0;
  int errors = 0;
  int eb[ND];

  loop_nest_ctrl #(.NDepth(ND), .IdxDW(W)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_start(i_start), .i_bound(i_bound),
    .i_abort(i_abort), .o_busy(o_busy), .o_valid(o_valid), .i_ready(i_ready),
    .o_idx(o_idx), .o_first(o_first), .o_last(o_last), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ND*W-1:0] model_idx(input int n);
    logic [ND*W-1:0] v;
    int div;
    v = '0;
    div = 1;
    for (int k = 0; k < ND; k++) begin
      v[k*W +: W] = W'((n / div) % eb[k]);
      div = div * eb[k];
    end
    return v;
  endfunction

  function automatic logic [ND-1:0] model_first(input int n);
    logic [ND-1:0] f;
    int div;
    div = 1;
    for (int k = 0; k < ND; k++) begin
      f[k] = (((n / div) % eb[k]) == 0);
      div = div * eb[k];
    end
    return f;
  endfunction

  function automatic logic [ND-1:0] model_last(input int n);
    logic [ND-1:0] l;
    int div;
    div = 1;
    for (int k = 0; k < ND; k++) begin
      l[k] = (((n / div) % eb[k]) == eb[k] - 1);
      div = div * eb[k];
    end
    return l;
  endfunction

  task automatic chk_tuple(input string tag, input int n);
    chk({tag, "_idx"},   64'(o_idx),   64'(model_idx(n)));
    chk({tag, "_first"}, 64'(o_first), 64'(model_first(n)));
    chk({tag, "_last"},  64'(o_last),  64'(model_last(n)));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_busy"},  64'(o_busy),  64'(0));
    chk({tag, "_done"},  64'(o_done),  64'(0));
    chk({tag, "_idx"},   64'(o_idx),   64'(0));
    chk({tag, "_first"}, 64'(o_first), 64'({ND{1'b1}}));
    chk({tag, "_last"},  64'(o_last),  64'({ND{1'b1}}));
  endtask

  // Called at a negedge; issues start there and runs the nest. Returns at the
  // negedge of the o_done cycle (normal end) or after abort/reset handling.
  task automatic run_nest(input string tag, input int b0, input int b1, input int b2,
                          input bit rnd_ready, input int abort_at, input int rst_at,
                          input bit hold_start);
    int b[ND];
    int total, n, cyc, budget;
    bit rdy;
    b[0] = b0; b[1] = b1; b[2] = b2;
    total = 1;
    for (int k = 0; k < ND; k++) begin
      eb[k] = (b[k] == 0) ? 1 : b[k];
      total = total * eb[k];
      i_bound[k*W +: W] = W'(b[k]);
    end
    i_start = 1'b1;
    i_abort = 1'b0;
    @(negedge i_clk);
    i_start = hold_start;
    n = 0;
    cyc = 0;
    budget = total * 8 + 50;
    while (n < total && cyc < budget) begin
      chk({tag, "_valid"}, 64'(o_valid), 64'(1));
      chk({tag, "_busy"},  64'(o_busy),  64'(1));
      chk({tag, "_done"},  64'(o_done),  64'(0));
      chk_tuple(tag, n);
      if (hold_start) i_bound = ND*W'($urandom);
      if (n == abort_at) begin
        i_abort = 1'b1;
        i_ready = 1'b1;
        @(negedge i_clk);
        i_abort = 1'b0;
        i_start = 1'b0;
        chk({tag, "_abort_valid"}, 64'(o_valid), 64'(0));
        chk({tag, "_abort_busy"},  64'(o_busy),  64'(0));
        chk({tag, "_abort_done"},  64'(o_done),  64'(0));
        chk({tag, "_abort_idx"},   64'(o_idx),   64'(model_idx(n)));
        @(negedge i_clk);
        chk({tag, "_abort_done2"}, 64'(o_done), 64'(0));
        $display("nest %s aborted at beat %0d", tag, n);
        return;
      end
      if (n == rst_at) begin
        i_rstn = 1'b0;
        @(negedge i_clk);
        i_rstn = 1'b1;
        i_start = 1'b0;
        chk_reset_state({tag, "_rst"});
        @(negedge i_clk);
        chk({tag, "_rst_done2"}, 64'(o_done), 64'(0));
        $display("nest %s reset at beat %0d", tag, n);
        return;
      end
      rdy = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      i_ready = rdy;
      @(negedge i_clk);
      if (rdy) n++;
      cyc++;
    end
    i_start = 1'b0;
    chk({tag, "_timeout"}, 64'(cyc < budget), 64'(1));
    chk({tag, "_end_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_end_busy"},  64'(o_busy),  64'(0));
    chk({tag, "_end_done"},  64'(o_done),  64'(1));
    chk({tag, "_end_idx"},   64'(o_idx),   64'(model_idx(total - 1)));
    $display("nest %s bounds %0d/%0d/%0d: %0d beats in %0d cycles", tag, b0, b1, b2, n, cyc);
  endtask

  task automatic idle_check(input string tag);
    @(negedge i_clk);
    chk({tag, "_idle_done"},  64'(o_done),  64'(0));
    chk({tag, "_idle_valid"}, 64'(o_valid), 64'(0));
    chk({tag, "_idle_busy"},  64'(o_busy),  64'(0));
  endtask

  initial begin
    repeat (2) @(negedge i_clk);
    chk_reset_state("reset");
    i_rstn = 1'b1;
    i_abort = 1'b1;
    @(negedge i_clk);
    i_abort = 1'b0;
    chk_reset_state("abort_idle");

    run_nest("basic", 3, 2, 2, 1'b0, -1, -1, 1'b0);
    idle_check("basic");
    run_nest("bp", 3, 2, 2, 1'b1, -1, -1, 1'b0);
    idle_check("bp");
    run_nest("degen", 0, 1, 0, 1'b0, -1, -1, 1'b0);
    idle_check("degen");
    run_nest("maxb", 2047, 1, 1, 1'b0, -1, -1, 1'b0);
    idle_check("maxb");
    run_nest("abort", 4, 4, 4, 1'b0, 10, -1, 1'b0);
    run_nest("post_abort", 2, 2, 2, 1'b1, -1, -1, 1'b0);
    idle_check("post_abort");
    run_nest("hold", 2, 3, 2, 1'b1, -1, -1, 1'b1);
    run_nest("chain", 3, 1, 2, 1'b0, -1, -1, 1'b0);
    idle_check("chain");
    run_nest("rst", 4, 4, 4, 1'b0, -1, 5, 1'b0);
    run_nest("post_rst", 3, 3, 1, 1'b1, -1, -1, 1'b0);
    idle_check("post_rst");
    for (int r = 0; r < 6; r++) begin
      run_nest($sformatf("rnd%0d", r), int'($urandom_range(0, 5)), int'($urandom_range(0, 4)),
               int'($urandom_range(0, 3)), 1'b1, -1, -1, 1'b0);
      idle_check($sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/loop_nest_ctrl.md
# loop_nest_ctrl

Parametrised nested-loop iteration generator with a valid/ready output stream, used by the accelerator control path to sequence NDepth-deep loop nests (e.g. channel/row/column tiling). It is the successor to the single-step loop counter. It latches per-level bounds on a start command, emits one index tuple per accepted beat, and flags first/last per level. It stalls on back-pressure, supports abort, and signals completion with a done pulse.

## Interface
Parameters:
- NDepth, 3, number of nested loop levels; level 0 is innermost.
- IdxDW, 11, index/bound width per level; each level iterates at most 2^IdxDW-1 times.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rstn  in  1  reset, synchronous and active-low; sampled on i_clk rising edge.
- i_start  in  1  start command; accepted only in IDLE.
- i_bound  in  NDepth*IdxDW  iteration counts; level k in bits [k*IdxDW +: IdxDW]; sampled only when start is accepted.
- i_abort  in  1  terminate the current nest; effective only in RUN.
- o_busy  out  1  high in RUN.
- o_valid  out  1  current index tuple is valid.
- i_ready  in  1  consumer accepts the tuple; a beat occurs when o_valid & i_ready.
- o_idx  out  NDepth*IdxDW  current indices, 0-based, packed like i_bound.
- o_first  out  NDepth  o_first[k] = (idx[k] == 0).
- o_last  out  NDepth  o_last[k] = (idx[k] == bound_r[k]-1).
- o_done  out  1  one-cycle pulse after the final beat.

## Operation
- FSM with two states.
  - IDLE: o_busy=0, o_valid=0.
  - RUN: o_busy=1, o_valid=1.
- IDLE -> RUN when i_start=1.
  - bound_r[k] <= (i_bound[k]==0) ? 1 : i_bound[k]. A zero bound runs one iteration.
  - All idx <= 0.
- i_start in RUN is ignored. It is neither queued nor does it affect the bounds.
- On a beat in RUN, the nest advances like an odometer:
  - Level 0 increments, or wraps to 0 when o_last[0].
  - Level k>0 changes only when &o_last[k-1:0]. It then increments, or wraps to 0 when o_last[k].
- Final beat: a beat with &o_last[NDepth-1:0] = 1.
  - FSM -> IDLE; idx holds its last values.
  - o_done=1 for exactly one cycle, the cycle following the final beat.
- Abort: i_abort in RUN -> IDLE next cycle.
  - Abort has priority over a same-cycle beat. That beat counts as accepted by the consumer, but idx does not advance.
  - No o_done is generated.
  - i_abort in IDLE is ignored.
- While o_valid=1 and i_ready=0, o_idx/o_first/o_last hold stable.
- o_first/o_last are decoded from registered idx and bound_r. They are don't-care when o_valid=0, but must not be X.
- Total beats per nest = product of bound_r[k].
- No arithmetic overflow: idx never exceeds bound_r-1 < 2^IdxDW-1.

## Timing
- Reset (i_rstn=0 at an edge), values after that edge:
  - State IDLE.
  - o_busy=0, o_valid=0, o_done=0.
  - o_idx=0, o_first=all-ones.
  - bound_r=1 per level, so o_last=all-ones.
- Reset mid-RUN aborts silently, with no o_done.
- Start latency: i_start sampled at edge t; o_valid=1 with idx all-zero from edge t onward. The first beat is possible in cycle t+1.
- Throughput: one beat per cycle while i_ready=1. There are no bubbles between beats, including at level wrap-around.
- Completion: final beat at edge t. At t, o_valid drops and o_done rises. At t+1, o_done falls.
- A new i_start is accepted in the o_done cycle (state is IDLE). This gives back-to-back nests with a one-cycle o_valid gap.
- All outputs are registered or decoded only from registers. There is no combinational path from i_ready or i_abort to any output.

## Test plan
- Basic nest: bounds {lvl0=3, lvl1=2, lvl2=2}, i_ready=1 -> 12 consecutive beats.
  - idx sequence (l2,l1,l0): 000,001,002,010,...,112.
  - o_last=3'b111 only on beat 12; o_done one cycle later.
- Back-pressure: same bounds, i_ready toggling pseudo-randomly -> identical 12-tuple sequence, outputs stable while stalled, exactly 12 beats.
- Degenerate bounds: bounds {0,1,0} -> exactly 1 beat with o_first=o_last=3'b111, then o_done. Max bound 2047 on lvl0 with others 1 -> 2047 beats, last idx 2046.
- Abort: bounds {4,4,4}, assert i_abort with i_ready=1 at beat 10 -> o_valid low next cycle, no o_done, o_busy=0. A new i_start restarts from idx 0.
- Start rules: i_start held in RUN -> ignored, and bound changes mid-run have no effect. i_start in the o_done cycle -> new nest starts with o_valid after one idle cycle.
- Reset mid-run: i_rstn=0 at beat 5 -> all outputs at reset values after that edge, no o_done. Run resumes correctly after the next i_start.
